b16_dbg_host: RTL and testbench

B16_DBG_HOST -- requirements
Module: b16_dbg_host

---
 rtl/b16_dbg_pkg.sv | 40 ++++
 rtl/b16_dbg_host.sv | 162 ++++++++++++++++
 tb/tb_b16_dbg_host.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/b16_dbg_pkg.sv
// Shared constants and types for the b16 debug host: opcodes, register indices, FSM states.
package b16_dbg_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADDR_W = 3;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_HALT  = 2'b10;
  localparam logic [1:0] OP_RUN   = 2'b11;

  // Within OP_RUN, this command bit selects STEP instead of RESUME.
  localparam int unsigned STEP_BIT = 0;

  localparam logic [ADDR_W-1:0] REG_N      = 3'd0;
  localparam logic [ADDR_W-1:0] REG_RSTACK = 3'd1;
  localparam logic [ADDR_W-1:0] REG_BP     = 3'd2;
  localparam logic [ADDR_W-1:0] REG_STATUS = 3'd3;
  localparam logic [ADDR_W-1:0] REG_P      = 3'd4;
  localparam logic [ADDR_W-1:0] REG_T      = 3'd5;
  localparam logic [ADDR_W-1:0] REG_R      = 3'd6;
  localparam logic [ADDR_W-1:0] REG_I      = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WHI  = 3'd1,
    S_WLO  = 3'd2,
    S_WSTB = 3'd3,
    S_RSTB = 3'd4,
    S_THI  = 3'd5,
    S_TLO  = 3'd6,
    S_STEP = 3'd7
  } state_t;

  // States in which a host byte may be accepted.
  function automatic logic rx_state(input state_t s);
    return (s == S_IDLE) || (s == S_WHI) || (s == S_WLO);
  endfunction

endpackage

// File: rtl/b16_dbg_host.sv
// Byte-serial host link to b16 CPU debug port: halt/resume/step and register read/write.
module b16_dbg_host
  import b16_dbg_pkg::*;
#(
  parameter int unsigned l = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              drun,
  output logic              dr,
  output logic              dw,
  output logic [ADDR_W-1:0] daddr,
  output logic [l-1:0]      din,
  input  logic [l-1:0]      dout
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_rx_ready;
  logic [BYTE_W-1:0] r_tx_data;
  logic              r_tx_valid;
  logic              r_drun;
  logic              r_dr;
  logic              r_dw;
  logic [ADDR_W-1:0] r_daddr;
  logic [l-1:0]      r_din;
  logic [l-1:0]      r_hold;

  logic [BYTE_W-1:0] w_tx_data_nxt;
  logic              w_drun_nxt;
  logic              w_dr_nxt;
  logic              w_dw_nxt;
  logic [ADDR_W-1:0] w_daddr_nxt;
  logic [l-1:0]      w_din_nxt;
  logic [l-1:0]      w_hold_nxt;
  logic              w_acc;
  logic [1:0]        w_op;
  logic [l-1:0]      w_rd_word;
  logic              w_unused;

  assign w_acc     = rx_valid && r_rx_ready;
  assign w_op      = rx_data[7:6];
  // A read while running returns zero since no strobe reaches the CPU.
  assign w_rd_word = r_dr ? dout : l'(0);
  assign w_unused  = ^rx_data[5:3];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_drun_nxt    = r_drun;
    w_daddr_nxt   = r_daddr;
    w_din_nxt     = r_din;
    w_hold_nxt    = r_hold;
    w_tx_data_nxt = r_tx_data;
    w_dr_nxt      = 1'b0;
    w_dw_nxt      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          w_daddr_nxt = rx_data[ADDR_W-1:0];
          case (w_op)
            OP_READ:  w_state_nxt = S_RSTB;
            OP_WRITE: w_state_nxt = S_WHI;
            OP_HALT:  w_drun_nxt  = 1'b0;
            default: begin
              if (!rx_data[STEP_BIT]) begin
                w_drun_nxt = 1'b1;
              end else if (!r_drun) begin
                w_drun_nxt  = 1'b1;
                w_state_nxt = S_STEP;
              end
            end
          endcase
        end
      end
      S_WHI: begin
        if (w_acc) begin
          w_din_nxt[l-1 -: BYTE_W] = rx_data;
          w_state_nxt              = S_WLO;
        end
      end
      S_WLO: begin
        if (w_acc) begin
          w_din_nxt[BYTE_W-1:0] = rx_data;
          w_state_nxt           = S_WSTB;
        end
      end
      S_WSTB: w_state_nxt = S_IDLE;
      S_RSTB: begin
        w_hold_nxt    = w_rd_word;
        w_tx_data_nxt = w_rd_word[l-1 -: BYTE_W];
        w_state_nxt   = S_THI;
      end
      S_THI: begin
        if (tx_ready) begin
          w_tx_data_nxt = r_hold[BYTE_W-1:0];
          w_state_nxt   = S_TLO;
        end
      end
      S_TLO: begin
        if (tx_ready) begin
          w_tx_data_nxt = '0;
          w_state_nxt   = S_IDLE;
        end
      end
      S_STEP: begin
        w_drun_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Strobes fire in the state entered; drun is unchanged on these paths.
    w_dr_nxt = (w_state_nxt == S_RSTB) && (r_state != S_RSTB) && !r_drun;
    w_dw_nxt = (w_state_nxt == S_WSTB) && (r_state != S_WSTB) && !r_drun;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_ready <= 1'b1;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
      r_drun     <= 1'b1;
      r_dr       <= 1'b0;
      r_dw       <= 1'b0;
      r_daddr    <= '0;
      r_din      <= '0;
      r_hold     <= '0;
    end else begin
      r_rx_ready <= rx_state(w_state_nxt);
      r_tx_valid <= (w_state_nxt == S_THI) || (w_state_nxt == S_TLO);
      r_tx_data  <= w_tx_data_nxt;
      r_drun     <= w_drun_nxt;
      r_dr       <= w_dr_nxt;
      r_dw       <= w_dw_nxt;
      r_daddr    <= w_daddr_nxt;
      r_din      <= w_din_nxt;
      r_hold     <= w_hold_nxt;
    end
  end

  assign rx_ready = r_rx_ready;
  assign tx_valid = r_tx_valid;
  assign tx_data  = r_tx_data;
  assign drun     = r_drun;
  assign dr       = r_dr;
  assign dw       = r_dw;
  assign daddr    = r_daddr;
  assign din      = r_din;

endmodule

// File: tb/tb_b16_dbg_host.sv
// Directed bench for b16_dbg_host: halt, step, register read/write and mid-command reset.
module tb_b16_dbg_host;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        drun;
  logic        dr;
  logic        dw;
  logic [2:0]  daddr;
  logic [15:0] din;
  logic [15:0] dout;

  int checks = 0;
  int errors = 0;

  // Monitor-owned observations; tasks take snapshots rather than clearing.
  int          dr_cnt = 0;
  int          dw_cnt = 0;
  int          viol   = 0;
  logic [15:0] dw_din;
  logic [2:0]  dw_addr;
  logic [2:0]  dr_addr;
  logic [7:0]  tx_q[$];

  b16_dbg_host #(.l(16)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .drun(drun), .dr(dr), .dw(dw), .daddr(daddr),
    .din(din), .dout(dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) begin
      if (dr) begin dr_cnt <= dr_cnt + 1; dr_addr <= daddr; end
      if (dw) begin dw_cnt <= dw_cnt + 1; dw_addr <= daddr; dw_din <= din; end
      if ((dr && dw) || ((dr || dw) && drun)) viol <= viol + 1;
      if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin @(negedge clk); n++; end
    if (!rx_ready) begin
      checks++; errors++;
      $display("FAIL send_byte timeout byte=%02h rx_ready=%b need 1", b, rx_ready);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int need);
    int n = 0;
    while (tx_q.size() < need && n < 40) begin @(negedge clk); n++; end
  endtask

  task automatic test_reset;
    reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0; dout = 16'h0;
    #12;
    checks++;
    if ({drun, dr, dw, daddr, din, tx_valid, tx_data} !== {1'b1, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 8'h0}) begin
      errors++;
      $display("FAIL reset_outputs drun=%b dr=%b dw=%b daddr=%0d din=%h txv=%b txd=%h need 1 0 0 0 0000 0 00",
               drun, dr, dw, daddr, din, tx_valid, tx_data);
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready got %b need 1", rx_ready); end
  endtask

  task automatic test_halt;
    int q0 = tx_q.size();
    send_byte(8'h80);
    checks++;
    if (drun !== 1'b0) begin errors++; $display("FAIL halt_drun got %b need 0", drun); end
    repeat (4) @(negedge clk);
    checks++;
    if (tx_q.size() != q0) begin errors++; $display("FAIL halt_no_tx got %0d bytes need 0", tx_q.size() - q0); end
  endtask

  task automatic test_write;
    int w0 = dw_cnt;
    send_byte(8'h45); send_byte(8'h12); send_byte(8'h34);
    repeat (3) @(negedge clk);
    checks++;
    if (dw_cnt - w0 != 1) begin errors++; $display("FAIL write_dw_count got %0d need 1", dw_cnt - w0); end
    checks++;
    if (dw_addr !== 3'd5 || dw_din !== 16'h1234) begin
      errors++; $display("FAIL write_payload daddr=%0d din=%h need 5 1234", dw_addr, dw_din);
    end
  endtask

  task automatic test_read;
    int r0 = dr_cnt;
    int q0 = tx_q.size();
    int bad = 0;
    dout = 16'hBEEF; tx_ready = 1'b0;
    send_byte(8'h05);
    checks++;
    if (dr !== 1'b1 || daddr !== 3'd5) begin errors++; $display("FAIL read_strobe dr=%b daddr=%0d need 1 5", dr, daddr); end
    @(posedge clk); #1;
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hBE) begin
      errors++; $display("FAIL read_latency txv=%b txd=%h need 1 be", tx_valid, tx_data);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (tx_valid !== 1'b1 || tx_data !== 8'hBE) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL read_hold unstable cycles=%0d need 0", bad); end
    tx_ready = 1'b1;
    wait_tx(q0 + 2);
    tx_ready = 1'b0;
    checks++;
    if (tx_q.size() != q0 + 2) begin
      errors++; $display("FAIL read_tx_count got %0d need 2", tx_q.size() - q0);
    end else if (tx_q[q0] !== 8'hBE || tx_q[q0+1] !== 8'hEF) begin
      errors++; $display("FAIL read_tx_bytes got %h %h need be ef", tx_q[q0], tx_q[q0+1]);
    end
    @(negedge clk);
    checks++;
    if (dr_cnt - r0 != 1 || dr_addr !== 3'd5 || tx_valid !== 1'b0) begin
      errors++; $display("FAIL read_dr_pulse count=%0d addr=%0d txv=%b need 1 5 0", dr_cnt - r0, dr_addr, tx_valid);
    end
  endtask

  task automatic test_step;
    int bad = 0;
    send_byte(8'hC1);
    checks++;
    if (drun !== 1'b1) begin errors++; $display("FAIL step_run got %b need 1", drun); end
    @(posedge clk); #1;
    checks++;
    if (drun !== 1'b0 || rx_ready !== 1'b1) begin
      errors++; $display("FAIL step_return drun=%b rx_ready=%b need 0 1", drun, rx_ready);
    end
    send_byte(8'hC0);
    checks++;
    if (drun !== 1'b1) begin errors++; $display("FAIL resume_drun got %b need 1", drun); end
    send_byte(8'hC1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (drun !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL step_running drun low cycles=%0d need 0", bad); end
  endtask

  task automatic test_running;
    int r0 = dr_cnt;
    int w0 = dw_cnt;
    int q0 = tx_q.size();
    dout = 16'hBEEF; tx_ready = 1'b1;
    send_byte(8'h00);
    wait_tx(q0 + 2);
    tx_ready = 1'b0;
    checks++;
    if (tx_q.size() != q0 + 2) begin
      errors++; $display("FAIL run_read_count got %0d need 2", tx_q.size() - q0);
    end else if (tx_q[q0] !== 8'h00 || tx_q[q0+1] !== 8'h00) begin
      errors++; $display("FAIL run_read_bytes got %h %h need 00 00", tx_q[q0], tx_q[q0+1]);
    end
    send_byte(8'h40); send_byte(8'hAA); send_byte(8'h55);
    repeat (3) @(negedge clk);
    checks++;
    if (dr_cnt != r0 || dw_cnt != w0) begin
      errors++; $display("FAIL run_no_strobe dr=%0d dw=%0d need 0 0", dr_cnt - r0, dw_cnt - w0);
    end
    checks++;
    if (din !== 16'hAA55 || viol != 0) begin
      errors++; $display("FAIL run_din din=%h viol=%0d need aa55 0", din, viol);
    end
  endtask

  task automatic test_reset_mid;
    int w0;
    int q0;
    send_byte(8'h80);
    send_byte(8'h45); send_byte(8'h12);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    checks++;
    if (drun !== 1'b1 || rx_ready !== 1'b1) begin
      errors++; $display("FAIL midreset_state drun=%b rx_ready=%b need 1 1", drun, rx_ready);
    end
    reset = 1'b1;
    w0 = dw_cnt; q0 = tx_q.size();
    repeat (3) @(negedge clk);
    checks++;
    if (dw_cnt != w0 || tx_q.size() != q0) begin
      errors++; $display("FAIL midreset_abandon dw=%0d tx=%0d need 0 0", dw_cnt - w0, tx_q.size() - q0);
    end
    tx_ready = 1'b1;
    send_byte(8'h05);
    checks++;
    if (daddr !== 3'd5) begin errors++; $display("FAIL midreset_daddr got %0d need 5", daddr); end
    wait_tx(q0 + 2);
    tx_ready = 1'b0;
    checks++;
    if (tx_q.size() != q0 + 2 || dw_cnt != w0) begin
      errors++; $display("FAIL midreset_fresh_read tx=%0d dw=%0d need 2 0", tx_q.size() - q0, dw_cnt - w0);
    end
  endtask

  initial begin
    test_reset();
    test_halt();
    test_write();
    test_read();
    test_step();
    test_running();
    test_reset_mid();
    checks++;
    if (viol != 0) begin errors++; $display("FAIL strobe_rule violations=%0d need 0", viol); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
